// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access; data side has priority.
// Optional build macro ARB_ALIGN_CHK_EN rejects odd addresses at grant time with an err pulse.
module mem_arbiter #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              dm_en,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_stall,
  input  logic              halt,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyDm, StHalted} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              halted_q, halted_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_done_q, if_done_d;
  logic              dm_done_q, dm_done_d;
  logic              err_q, err_d;
  logic              halt_now;
  state_e            rest_st;

  // Halt is only honoured outside a busy window; once seen it sticks until reset.
  assign halt_now = halted_q | halt;
  assign rest_st  = halt_now ? StHalted : StIdle;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    halted_d   = halted_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_done_d  = 1'b0;
    dm_done_d  = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle, StHalted: begin
        halted_d = halt_now;
        state_d  = rest_st;
        if (dm_wr && !dm_en) begin
          err_d = 1'b1;
        end else if (dm_en) begin
          addr_d  = dm_addr;
          wdata_d = dm_wdata;
          wr_d    = dm_wr;
`ifdef ARB_ALIGN_CHK_EN
          if (dm_addr[0]) begin
            dm_done_d = 1'b1;
            err_d     = 1'b1;
          end else
`endif
          begin
            state_d = StBusyDm;
            cnt_d   = 3'd1;
          end
        end else if (if_req && !halt_now) begin
          addr_d = if_addr;
          wr_d   = 1'b0;
`ifdef ARB_ALIGN_CHK_EN
          if (if_addr[0]) begin
            if_done_d = 1'b1;
            err_d     = 1'b1;
          end else
`endif
          begin
            state_d = StBusyIf;
            cnt_d   = 3'd1;
          end
        end
      end
      StBusyIf, StBusyDm: begin
        if (cnt_q == 3'(LATENCY)) begin
          cnt_d    = 3'd0;
          halted_d = halt_now;
          state_d  = rest_st;
          if (state_q == StBusyIf) begin
            if_rdata_d = mem_rdata;
            if_done_d  = 1'b1;
          end else begin
            // Stores complete without disturbing the last load result.
            if (!wr_q) dm_rdata_d = mem_rdata;
            dm_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      halted_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      halted_q   <= halted_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
      err_q      <= err_d;
    end
  end

  assign mem_en    = (state_q == StBusyIf) || (state_q == StBusyDm);
  assign mem_wr    = (state_q == StBusyDm) && wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign err       = err_q;
  // Stalls are forced low while reset is asserted so every output reads 0 in reset.
  assign if_stall  = rst && ((if_req && !if_done_q) || halted_q);
  assign dm_stall  = rst && dm_en && !dm_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-numbered transaction model checks every cycle,
// and literal expectations at hand-computed cycles pin the model.
module tb_mem_arbiter;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_en, dm_wr, halt;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_done, if_stall, dm_done, dm_stall, mem_en, mem_wr, err;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.LATENCY(LAT), .ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .if_stall(if_stall),
    .dm_en(dm_en), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .halt(halt),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a grant at the edge ending cycle g occupies cycles g+1..g+LAT,
  // and the matching done pulse lands in cycle g+LAT+1.
  int          c = 0;
  bit          m_ok = 0;
  int          bs = 1, be = 0, ifd = -1, dmd = -1, erc = -1;
  bit          mh = 0, mdm = 0, mwr = 0, en_e, odd;
  logic [15:0] maddr = '0, mwd = '0, mifr = '0, mdmr = '0;

  always @(negedge clk) begin : model
    en_e = (c >= bs) && (c <= be);
    if (m_ok) begin
      chk("mem_en", {31'd0, mem_en}, {31'd0, en_e});
      chk("mem_wr", {31'd0, mem_wr}, {31'd0, en_e && mdm && mwr});
      if (en_e) chk("mem_addr", {16'd0, mem_addr}, {16'd0, maddr});
      if (en_e && mdm && mwr) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, mwd});
      chk("if_done", {31'd0, if_done}, {31'd0, c == ifd});
      chk("dm_done", {31'd0, dm_done}, {31'd0, c == dmd});
      chk("err", {31'd0, err}, {31'd0, c == erc});
      chk("if_rdata", {16'd0, if_rdata}, {16'd0, mifr});
      chk("dm_rdata", {16'd0, dm_rdata}, {16'd0, mdmr});
      chk("if_stall", {31'd0, if_stall},
          {31'd0, rst && ((if_req && c != ifd) || mh)});
      chk("dm_stall", {31'd0, dm_stall}, {31'd0, rst && dm_en && c != dmd});
    end
    if (!rst) begin
      bs = 1; be = 0; ifd = -1; dmd = -1; erc = -1;
      mh = 0; mdm = 0; mwr = 0; maddr = '0; mwd = '0; mifr = '0; mdmr = '0;
      bs = c + 1; be = c;
      m_ok = 1;
    end else if (en_e) begin
      if (c == be) begin
        if (!mdm) begin
          mifr = mem_rdata; ifd = c + 1;
        end else begin
          if (!mwr) mdmr = mem_rdata;
          dmd = c + 1;
        end
        mh = mh | halt;
      end
    end else begin
      mh = mh | halt;
      if (dm_wr && !dm_en) begin
        erc = c + 1;
      end else if (dm_en || (if_req && !mh)) begin
        mdm   = dm_en;
        maddr = dm_en ? dm_addr : if_addr;
        mwr   = dm_en && dm_wr;
        if (dm_en) mwd = dm_wdata;
`ifdef ARB_ALIGN_CHK_EN
        odd = maddr[0];
`else
        odd = 1'b0;
`endif
        if (odd) begin
          erc = c + 1;
          if (mdm) dmd = c + 1; else ifd = c + 1;
        end else begin
          bs = c + 1; be = c + LAT;
        end
      end
    end
    c++;
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk_all_zero();
    chk("rst_outs", {16'd0, mem_en, mem_wr, if_done, dm_done, err, if_stall, dm_stall, 9'd0},
        32'd0);
    chk("rst_data", {mem_addr, if_rdata}, 32'd0);
    chk("rst_data2", {mem_wdata, dm_rdata}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; if_req = 1'b1; if_addr = 16'h0000; dm_en = 1'b0; dm_wr = 1'b0;
    dm_addr = '0; dm_wdata = '0; halt = 1'b0; mem_rdata = 16'hA5C3;

    // Reset for two edges with a fetch pending, then a plain fetch.
    nxt(); mid(); chk_all_zero();
    nxt(); mid(); chk_all_zero();
    nxt(); rst = 1'b1;
    mid(); chk("t1_c0_en", {31'd0, mem_en}, 32'd0); chk("t1_c0_stall", {31'd0, if_stall}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      nxt();
      if (k == 3) if_req = 1'b0;
      mid();
      if (k <= 2) chk("t1_busy", {31'd0, mem_en}, 32'd1);
      if (k == 3) chk("t1_done", {15'd0, if_done, if_rdata}, {15'd0, 1'b1, 16'hA5C3});
      if (k == 4) chk("t1_after", {30'd0, if_done, mem_en}, 32'd0);
    end

    // Simultaneous fetch and load: data side first.
    nxt(); if_req = 1'b1; if_addr = 16'h0100; dm_en = 1'b1; dm_addr = 16'h0040;
    mem_rdata = 16'h1234;
    mid(); chk("t2_stall0", {30'd0, if_stall, dm_stall}, 32'd3);
    for (int k = 1; k <= 6; k++) begin
      nxt();
      if (k == 3) begin dm_en = 1'b0; mem_rdata = 16'h5678; end
      if (k == 6) if_req = 1'b0;
      mid();
      if (k == 1 || k == 2) chk("t2_dm_busy", {15'd0, mem_en, mem_addr}, {15'd0, 1'b1, 16'h0040});
      if (k == 3) chk("t2_dm_done", {15'd0, dm_done, dm_rdata}, {15'd0, 1'b1, 16'h1234});
      if (k == 4 || k == 5) chk("t2_if_busy", {15'd0, mem_en, mem_addr}, {15'd0, 1'b1, 16'h0100});
      if (k == 6) chk("t2_if_done", {15'd0, if_done, if_rdata}, {15'd0, 1'b1, 16'h5678});
      if (k <= 5) chk("t2_if_stall", {31'd0, if_stall}, 32'd1);
    end

    // Store.
    nxt(); dm_en = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0010; dm_wdata = 16'hBEEF;
    mem_rdata = 16'hDEAD;
    for (int k = 1; k <= 3; k++) begin
      nxt();
      if (k == 3) begin dm_en = 1'b0; dm_wr = 1'b0; end
      mid();
      if (k < 3) chk("t3_store", {mem_wr, mem_addr[14:0], mem_wdata},
                     {1'b1, 15'h0010, 16'hBEEF});
      if (k == 3) chk("t3_done", {15'd0, dm_done, dm_rdata}, {15'd0, 1'b1, 16'h1234});
    end

    // Write without enable is illegal.
    nxt(); dm_wr = 1'b1;
    mid();
    nxt(); dm_wr = 1'b0;
    mid(); chk("err_pulse", {30'd0, err, mem_en}, 32'd2);
    nxt(); mid(); chk("err_clear", {31'd0, err}, 32'd0);

    // Halt during a fetch; a later load is still served.
    nxt(); if_req = 1'b1; if_addr = 16'h0200; mem_rdata = 16'h0F0F;
    for (int k = 1; k <= 12; k++) begin
      nxt();
      if (k == 1) halt = 1'b1;
      if (k == 4) halt = 1'b0;
      if (k == 6) begin dm_en = 1'b1; dm_addr = 16'h0044; mem_rdata = 16'h7777; end
      if (k == 9) dm_en = 1'b0;
      mid();
      if (k == 3) chk("t4_if_done", {15'd0, if_done, if_rdata}, {15'd0, 1'b1, 16'h0F0F});
      if (k == 7 || k == 8) chk("t4_dm_busy", {15'd0, mem_en, mem_addr}, {15'd0, 1'b1, 16'h0044});
      if (k == 9) chk("t4_dm_done", {15'd0, dm_done, dm_rdata}, {15'd0, 1'b1, 16'h7777});
      if (k == 4 || k == 5 || k == 6 || k >= 10) chk("t4_no_fetch", {31'd0, mem_en}, 32'd0);
      if (k >= 3) chk("t4_halt_stall", {31'd0, if_stall}, 32'd1);
    end
    nxt(); rst = 1'b0; if_req = 1'b0;
    mid();
    nxt(); rst = 1'b1;
    mid(); chk("t4_unhalt", {31'd0, if_stall}, 32'd0);
    nxt(); if_req = 1'b1; if_addr = 16'h0300;
    mid();
    nxt(); mid(); chk("t4_regrant", {15'd0, mem_en, mem_addr}, {15'd0, 1'b1, 16'h0300});
    nxt(); mid();
    nxt(); if_req = 1'b0;
    mid(); chk("t4_refetch", {15'd0, if_done, if_rdata}, {15'd0, 1'b1, 16'h7777});

    // Reset in the first busy cycle abandons the access.
    nxt(); dm_en = 1'b1; dm_addr = 16'h0080;
    nxt(); rst = 1'b0; dm_en = 1'b0;
    mid(); chk("t5_busy1", {31'd0, mem_en}, 32'd1);
    for (int k = 2; k <= 4; k++) begin
      nxt();
      rst = 1'b1;
      mid();
      chk("t5_abandon", {14'd0, mem_en, dm_done, dm_rdata}, 32'd0);
    end

    // Odd data address.
    nxt(); dm_en = 1'b1; dm_addr = 16'h0003; mem_rdata = 16'h3C3C;
`ifdef ARB_ALIGN_CHK_EN
    nxt(); dm_en = 1'b0;
    mid(); chk("t6_reject", {13'd0, mem_en, dm_done, err, dm_rdata}, {13'd0, 3'b011, 16'h0000});
    nxt(); mid(); chk("t6_quiet", {29'd0, mem_en, dm_done, err}, 32'd0);
`else
    for (int k = 1; k <= 3; k++) begin
      nxt();
      if (k == 3) dm_en = 1'b0;
      mid();
      if (k < 3) chk("t6_busy", {15'd0, mem_en, mem_addr}, {15'd0, 1'b1, 16'h0003});
      if (k == 3) chk("t6_done", {14'd0, dm_done, err, dm_rdata}, {14'd0, 2'b10, 16'h3C3C});
    end
`endif

    repeat (3) nxt();
    mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
